noc_packet_arbiter: RTL and testbench
=====================================

# noc_packet_arbiter

Packet-level round-robin arbiter that merges CHANNELS flit streams onto one NoC output link. It is the sequencing counterpart of the class demultiplexer: it sits in front of a router input or a network-adapter egress port and shares that link between requesters. Once a header flit is granted, the link is held for that channel until its last flit has transferred.

## Interface
- FLIT_WIDTH, 34: flit width. Bits [FLIT_WIDTH-1:FLIT_WIDTH-2] are the flit type: 2'b01 header, 2'b00 payload, 2'b10 last, 2'b11 single.
- CHANNELS, 3: number of input channels, legal range 2..8.
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- in_flit  in  CHANNELS*FLIT_WIDTH  channel c occupies bits [c*FLIT_WIDTH +: FLIT_WIDTH].
- in_valid  in  CHANNELS  per-channel valid.
- in_ready  out  CHANNELS  per-channel ready.
- out_flit  out  FLIT_WIDTH  merged flit.
- out_valid  out  1  merged valid.
- out_ready  in  1  downstream ready.
- out_grant  out  $clog2(CHANNELS)  index of the channel currently connected to the output.

## Operation
- Transfer on any side means valid && ready in the same cycle.
- The arbiter has two states, IDLE and LOCKED, plus a registered priority pointer `prio` and a registered granted channel `gnt`.
- **IDLE:**
  - The combinational round-robin pick `sel` is the first c with in_valid[c] set, searching from `prio` upward with wrap-around.
  - `sel` is forwarded with zero latency: out_flit = in_flit[sel], out_valid = 1, in_ready[sel] = out_ready, all other in_ready = 0.
  - Next state if the transferred flit is last or single: stay IDLE, prio <= sel+1 mod CHANNELS.
  - Next state otherwise, including when out_valid is high but not accepted: go to LOCKED with gnt <= sel. This keeps out_flit stable under backpressure.
  - If no input is valid: out_valid = 0 and state is unchanged.
- **LOCKED:**
  - Only channel gnt is connected: out_flit = in_flit[gnt], out_valid = in_valid[gnt], in_ready[gnt] = out_ready, all other in_ready = 0.
  - On transfer of a last or single flit: go to IDLE, prio <= gnt+1 mod CHANNELS.
  - Bubbles (in_valid[gnt] low mid-packet) keep the lock and drive out_valid = 0.
- The flit type is decoded only to detect the end of a packet. A payload or last flit seen in IDLE is arbitrated exactly like a header; there is no error flagging.
- out_grant = `sel` in IDLE and `gnt` in LOCKED.

## Timing
- Reset values:
  - State IDLE, prio = 0, gnt = 0.
  - While rst is high: out_valid = 0, in_ready = 0, out_grant = 0.
  - With `NOC_ARB_PKTCNT_EN`, all pkt_count fields = 0.
- Latency is 0 cycles from input to output. The path is purely combinational from in_* and out_ready to out_* and in_ready.
- Single-flit packets from different channels can transfer on consecutive cycles with no gap.
- After a last flit, the next packet (from any channel) can transfer in the following cycle.
- Simultaneous requests are resolved strictly by `prio`. A channel that has just been served becomes lowest priority.
- A reset asserted mid-packet drops the lock immediately. Upstream senders are assumed to be reset at the same time.

## Configuration
- `NOC_ARB_PKTCNT_EN` defined:
  - Adds output port pkt_count, CHANNELS*16 bits. Field c is the number of packets completed by channel c.
  - Field c increments on each last or single flit transferred from channel c.
  - Each field wraps from 16'hFFFF to 0 and is cleared by rst.
- `NOC_ARB_PKTCNT_EN` undefined: the port and its counters are absent, and arbitration behaviour is identical.

## Structure
- The shared package noc_pkg holds the flit-type constants (FLIT_TYPE_PAYLOAD, FLIT_TYPE_HEADER, FLIT_TYPE_LAST, FLIT_TYPE_SINGLE) and the arbiter state enum {ARB_IDLE, ARB_LOCKED}.
- One combinational sub-module, noc_rr_select:
  - Parameter N.
  - Inputs req[N] and prio[$clog2(N)].
  - Outputs sel and any.
  - It is reusable by other NoC arbiters.

## Test plan
- CHANNELS=3, prio=0, all three channels offer a single flit in the same cycle, out_ready=1 -> output order ch0, ch1, ch2 on three consecutive cycles; prio ends at 0.
- ch1 sends a 4-flit packet (header, payload, payload, last) while ch0 requests from its second cycle -> the four ch1 flits appear contiguously, then ch0 wins; in_ready[0] = 0 throughout the ch1 packet.
- ch2 header is presented with out_ready=0 for 5 cycles while ch0 raises valid in cycle 2 -> out_flit stays equal to the ch2 header and out_grant = 2 throughout; ch0 is served only after the ch2 last flit.
- Locked on ch1, in_valid[1] drops for 3 cycles mid-packet -> out_valid = 0 for those 3 cycles, lock is held, and the packet completes afterwards.
- rst asserted on the cycle after a ch1 header transfer -> the next cycle shows out_valid = 0 and all in_ready = 0; after reset, ch0 has priority.
- With `NOC_ARB_PKTCNT_EN`: send 65537 single flits on ch0 -> pkt_count[15:0] = 1; all other fields remain 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type encodings and the packet-arbiter state enum.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Flit type lives in the top two bits of every flit. Bit 1 set marks the end of a packet.
package noc_pkg;

  localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
  localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // True for the flit that closes a packet (last or single).
  function automatic logic is_pkt_end(input logic [1:0] flit_type);
    return (flit_type == FLIT_TYPE_LAST) || (flit_type == FLIT_TYPE_SINGLE);
  endfunction

endpackage

// File: rtl/noc_rr_select.sv
// Round-robin pick: the first set req bit at or above prio, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller gates the result with its own ready.
// Ports: req[N] requests, prio start index; sel chosen index (0 when none), any = some request set.
module noc_rr_select #(
  parameter  int N = 3,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] prio,
  output logic [W-1:0] sel,
  output logic         any
);

  int         idx;
  logic [W-1:0] cand;

  // Walk offsets from highest to lowest so the smallest offset from prio wins.
  always_comb begin
    sel  = '0;
    any  = 1'b0;
    idx  = 0;
    cand = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(prio) + i;
      if (idx >= N) idx = idx - N;
      cand = idx[W-1:0];
      if (req[cand]) begin
        sel = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_packet_arbiter.sv
// Packet-level round-robin arbiter merging CHANNELS flit streams onto one link; holds the link until last/single.
// Latency: 0 cycles, in_* / out_ready to out_* / in_ready are combinational.
// Backpressure: out_ready is passed straight to the connected channel's in_ready; all other channels see 0.
// Ports: clk, rst (sync, active-high); in_flit/in_valid/in_ready per channel; out_flit/out_valid/out_ready; out_grant.
// Option NOC_ARB_PKTCNT_EN adds pkt_count (16-bit wrapping completed-packet counter per channel).
module noc_packet_arbiter
  import noc_pkg::*;
#(
  parameter  int FLIT_WIDTH = 34,
  parameter  int CHANNELS   = 3,
  localparam int GW         = $clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]          out_flit,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [GW-1:0]                  out_grant
`ifdef NOC_ARB_PKTCNT_EN
  ,
  output logic [CHANNELS*16-1:0]         pkt_count
`endif
);

  arb_state_e state_q, state_d;
  logic [GW-1:0] prio_q, prio_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] sel, cur, cur_inc;
  logic          any;
  logic [1:0]    cur_type;
  logic          xfer, pkt_end;

  logic [FLIT_WIDTH-1:0] flit_arr [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
    assign flit_arr[c] = in_flit[c*FLIT_WIDTH +: FLIT_WIDTH];
  end

  noc_rr_select #(.N(CHANNELS)) u_rr_select (
    .req  (in_valid),
    .prio (prio_q),
    .sel  (sel),
    .any  (any)
  );

  always_comb begin
    // Connected channel: the fresh pick while idle, the held grant while locked.
    cur       = (state_q == ARB_LOCKED) ? gnt_q : sel;
    out_flit  = flit_arr[cur];
    cur_type  = out_flit[FLIT_WIDTH-1 -: 2];
    out_valid = 1'b0;
    in_ready  = '0;
    out_grant = '0;
    if (!rst) begin
      out_grant = cur;
      if (state_q == ARB_LOCKED) begin
        out_valid       = in_valid[gnt_q];
        in_ready[gnt_q] = out_ready;
      end else if (any) begin
        out_valid     = 1'b1;
        in_ready[sel] = out_ready;
      end
    end
    xfer    = out_valid && out_ready;
    pkt_end = xfer && is_pkt_end(cur_type);
    cur_inc = (cur == GW'(CHANNELS - 1)) ? '0 : cur + 1'b1;

    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (out_valid) begin
          if (pkt_end) begin
            prio_d = cur_inc;
          end else begin
            // Lock even when the flit stalls so out_flit cannot switch channel under backpressure.
            state_d = ARB_LOCKED;
            gnt_d   = sel;
          end
        end
      end
      ARB_LOCKED: begin
        if (pkt_end) begin
          state_d = ARB_IDLE;
          prio_d  = cur_inc;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      prio_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef NOC_ARB_PKTCNT_EN
  logic [15:0] cnt_q [CHANNELS];
  logic [15:0] cnt_d [CHANNELS];

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_d[c] = cnt_q[c];
      if (pkt_end && (cur == GW'(c))) cnt_d[c] = cnt_q[c] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (rst) cnt_q[c] <= '0;
      else     cnt_q[c] <= cnt_d[c];
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_cnt_out
    assign pkt_count[c*16 +: 16] = cnt_q[c];
  end
`endif

endmodule

// File: tb/tb_noc_packet_arbiter.sv
module tb_noc_packet_arbiter;
  import noc_pkg::*;

  localparam int FW = 34;
  localparam int CH = 3;
  localparam int GW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [CH*FW-1:0]   in_flit;
  logic [CH-1:0]      in_valid;
  logic [CH-1:0]      in_ready;
  logic [FW-1:0]      out_flit;
  logic               out_valid;
  logic               out_ready;
  logic [GW-1:0]      out_grant;
`ifdef NOC_ARB_PKTCNT_EN
  logic [CH*16-1:0]   pkt_count;
`endif

  always #5 clk = ~clk;

  noc_packet_arbiter #(.FLIT_WIDTH(FW), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_grant (out_grant)
`ifdef NOC_ARB_PKTCNT_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] src_q [CH][$];
  logic [CH-1:0] hold;

  typedef struct {
    logic [CH-1:0] vld;
    logic          exp_ov;
    logic [GW-1:0] exp_gnt;
    logic [CH-1:0] exp_rdy;
  } vec_t;

  vec_t vec [11];

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int ch, input int seq);
    logic [FW-1:0] f;
    f = {t, 4'(ch), 28'(seq)};
    return f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_src();
    for (int c = 0; c < CH; c++) begin
      if (src_q[c].size() > 0 && !hold[c]) begin
        in_valid[c]          = 1'b1;
        in_flit[c*FW +: FW]  = src_q[c][0];
      end else begin
        in_valid[c]          = 1'b0;
        in_flit[c*FW +: FW]  = '0;
      end
    end
  endtask

  // Every accepted output flit must be the next one the bench expects.
  task automatic sb_check();
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected none", out_flit);
      end else begin
        chk("sb_flit", out_flit, exp_q.pop_front());
      end
    end
  endtask

  task automatic settle();
    apply_src();
    @(negedge clk);
    sb_check();
  endtask

  task automatic advance();
    logic [CH-1:0] fired;
    fired = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++)
      if (fired[c]) src_q[c].delete(0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_flit   = '0;
    out_ready = 1'b0;
    hold      = '0;

    // Reset gating: requests present but nothing may be granted.
    @(posedge clk); #1;
    in_valid  = 3'b111;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_grant", out_grant, 0);
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = '0;

    // Three simultaneous singles leave in priority order 0,1,2.
    for (int c = 0; c < CH; c++) begin
      src_q[c].push_back(mk(FLIT_TYPE_SINGLE, c, 1));
      exp_q.push_back(mk(FLIT_TYPE_SINGLE, c, 1));
    end
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("s1_grant", out_grant, k);
      chk("s1_valid", out_valid, 1);
      advance();
    end
    settle();
    chk("s1_idle_valid", out_valid, 0);
    advance();

    // Table of single-flit request patterns; prio starts at 0 and tracks the last winner.
    vec[0]  = '{3'b000, 1'b0, 2'd0, 3'b000};
    vec[1]  = '{3'b111, 1'b1, 2'd0, 3'b001};
    vec[2]  = '{3'b100, 1'b1, 2'd2, 3'b100};
    vec[3]  = '{3'b110, 1'b1, 2'd1, 3'b010};
    vec[4]  = '{3'b011, 1'b1, 2'd0, 3'b001};
    vec[5]  = '{3'b101, 1'b1, 2'd2, 3'b100};
    vec[6]  = '{3'b101, 1'b1, 2'd0, 3'b001};
    vec[7]  = '{3'b001, 1'b1, 2'd0, 3'b001};
    vec[8]  = '{3'b111, 1'b1, 2'd1, 3'b010};
    vec[9]  = '{3'b111, 1'b1, 2'd2, 3'b100};
    vec[10] = '{3'b000, 1'b0, 2'd0, 3'b000};
    for (int i = 0; i < 11; i++) begin
      in_valid = vec[i].vld;
      for (int c = 0; c < CH; c++)
        in_flit[c*FW +: FW] = mk(FLIT_TYPE_SINGLE, c, 100 + i);
      if (vec[i].exp_ov) exp_q.push_back(mk(FLIT_TYPE_SINGLE, int'(vec[i].exp_gnt), 100 + i));
      @(negedge clk);
      sb_check();
      chk("tbl_out_valid", out_valid, vec[i].exp_ov);
      chk("tbl_in_ready", in_ready, vec[i].exp_rdy);
      if (vec[i].exp_ov) chk("tbl_grant", out_grant, vec[i].exp_gnt);
      @(posedge clk); #1;
    end
    in_valid = '0;

    // ch1 four-flit packet stays contiguous while ch0 waits.
    src_q[1].push_back(mk(FLIT_TYPE_HEADER, 1, 20));
    src_q[1].push_back(mk(FLIT_TYPE_PAYLOAD, 1, 21));
    src_q[1].push_back(mk(FLIT_TYPE_PAYLOAD, 1, 22));
    src_q[1].push_back(mk(FLIT_TYPE_LAST, 1, 23));
    for (int s = 20; s < 24; s++) exp_q.push_back(src_q[1][s-20]);
    exp_q.push_back(mk(FLIT_TYPE_SINGLE, 0, 30));
    for (int k = 0; k < 6; k++) begin
      if (k == 1) src_q[0].push_back(mk(FLIT_TYPE_SINGLE, 0, 30));
      settle();
      if (k < 4) begin
        chk("s2_grant", out_grant, 1);
        chk("s2_valid", out_valid, 1);
        chk("s2_rdy0", in_ready[0], 0);
      end
      if (k == 4) chk("s2_ch0_grant", out_grant, 0);
      if (k == 5) chk("s2_idle", out_valid, 0);
      advance();
    end

    // ch2 header stalled five cycles; ch0 arrives mid-stall and must wait.
    src_q[2].push_back(mk(FLIT_TYPE_HEADER, 2, 40));
    src_q[2].push_back(mk(FLIT_TYPE_LAST, 2, 41));
    exp_q.push_back(mk(FLIT_TYPE_HEADER, 2, 40));
    exp_q.push_back(mk(FLIT_TYPE_LAST, 2, 41));
    exp_q.push_back(mk(FLIT_TYPE_SINGLE, 0, 42));
    for (int k = 0; k < 8; k++) begin
      if (k == 2) src_q[0].push_back(mk(FLIT_TYPE_SINGLE, 0, 42));
      out_ready = (k >= 5);
      settle();
      if (k < 5) begin
        chk("s3_hold_flit", out_flit, mk(FLIT_TYPE_HEADER, 2, 40));
        chk("s3_hold_valid", out_valid, 1);
        chk("s3_hold_rdy", in_ready, 0);
      end
      if (k <= 6) chk("s3_grant", out_grant, 2);
      if (k == 7) chk("s3_ch0_grant", out_grant, 0);
      advance();
    end
    out_ready = 1'b1;

    // Bubble of three cycles inside a locked ch1 packet.
    src_q[1].push_back(mk(FLIT_TYPE_HEADER, 1, 50));
    src_q[1].push_back(mk(FLIT_TYPE_PAYLOAD, 1, 51));
    src_q[1].push_back(mk(FLIT_TYPE_LAST, 1, 52));
    exp_q.push_back(mk(FLIT_TYPE_HEADER, 1, 50));
    exp_q.push_back(mk(FLIT_TYPE_PAYLOAD, 1, 51));
    exp_q.push_back(mk(FLIT_TYPE_LAST, 1, 52));
    exp_q.push_back(mk(FLIT_TYPE_SINGLE, 0, 53));
    for (int k = 0; k < 8; k++) begin
      hold[1] = (k >= 1 && k <= 3);
      if (k == 1) src_q[0].push_back(mk(FLIT_TYPE_SINGLE, 0, 53));
      settle();
      if (k >= 1 && k <= 3) begin
        chk("s4_bubble_valid", out_valid, 0);
        chk("s4_bubble_rdy", in_ready, 3'b010);
      end
      if (k <= 5) chk("s4_grant", out_grant, 1);
      if (k == 6) chk("s4_ch0_grant", out_grant, 0);
      if (k == 7) chk("s4_idle", out_valid, 0);
      advance();
    end
    hold = '0;

    // Reset right after a ch1 header transfer drops the lock.
    src_q[1].push_back(mk(FLIT_TYPE_HEADER, 1, 60));
    src_q[1].push_back(mk(FLIT_TYPE_PAYLOAD, 1, 61));
    exp_q.push_back(mk(FLIT_TYPE_HEADER, 1, 60));
    settle();
    chk("s5_hdr_grant", out_grant, 1);
    advance();
    rst = 1'b1;
    settle();
    chk("s5_rst_valid", out_valid, 0);
    chk("s5_rst_rdy", in_ready, 0);
    chk("s5_rst_grant", out_grant, 0);
    advance();
    rst = 1'b0;
    for (int c = 0; c < CH; c++) src_q[c].delete();
    for (int c = 0; c < CH; c++) begin
      src_q[c].push_back(mk(FLIT_TYPE_SINGLE, c, 70));
      exp_q.push_back(mk(FLIT_TYPE_SINGLE, c, 70));
    end
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("s5_post_grant", out_grant, k);
      advance();
    end

`ifdef NOC_ARB_PKTCNT_EN
    // Counter wrap: 65537 singles on ch0 leave field 0 at 1.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("cnt_reset", pkt_count, 0);
    @(posedge clk); #1;
    in_valid = 3'b001;
    in_flit  = '0;
    in_flit[0 +: FW] = mk(FLIT_TYPE_SINGLE, 0, 0);
    repeat (65537) @(posedge clk);
    #1;
    in_valid = '0;
    @(negedge clk);
    chk("cnt_ch0_wrap", pkt_count[15:0], 16'd1);
    chk("cnt_others", pkt_count[CH*16-1:16], 0);
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
